// File: rtl/aes128_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_pkg
//  Description : Shared AES-128 definitions: forward S-box, round-constant
//                lookup and key-schedule state encoding. The encryptor's
//                SubBytes uses the same S-box definition.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes128_pkg;

    // Key-schedule controller states (explicit 1-bit encoding).
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_t;

    // Number of round keys produced for AES-128.
    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    // Forward S-box; entry 0x00 occupies the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // S-box lookup: shift the wanted entry up to the top byte.
    function automatic logic [7:0] aes_sbox_byte(input logic [7:0] b);
        logic [2047:0] shifted;
        shifted = SBOX_TABLE << {b, 3'b000};
        return shifted[2047:2040];
    endfunction

    // Round constant for rounds 1..10; other indices yield zero.
    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage : aes128_pkg
`default_nettype wire

// File: rtl/key_sub_word.sv
`default_nettype none
// ============================================================================
//  Module      : key_sub_word
//  Description : Combinational 32-bit SubWord: four parallel S-box lookups.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_sub_word
    import aes128_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // One S-box per byte lane; lanes are independent.
    for (genvar g_i = 0; g_i < 4; g_i++) begin : g_sbox
        assign word_out[8*g_i +: 8] = aes_sbox_byte(word_in[8*g_i +: 8]);
    end

endmodule : key_sub_word
`default_nettype wire

// File: rtl/aes128_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_key_schedule
//  Description : Iterative AES-128 key expansion, one round key per clock.
//                Holds the cipher key and ten registered round keys for the
//                downstream encryptor; keys_valid flags a complete set.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_key_schedule
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         keys_valid,
    output logic [127:0] cipher_key,
    output logic [127:0] round1_key,
    output logic [127:0] round2_key,
    output logic [127:0] round3_key,
    output logic [127:0] round4_key,
    output logic [127:0] round5_key,
    output logic [127:0] round6_key,
    output logic [127:0] round7_key,
    output logic [127:0] round8_key,
    output logic [127:0] round9_key,
    output logic [127:0] round10_key
);

    ks_state_t    r_state;
    ks_state_t    w_next_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_wk;
    logic [127:0] r_cipher_key;
    logic [127:0] r_round_key [1:10];
    logic         r_busy;
    logic         r_keys_valid;

    logic         w_load;
    logic         w_step;
    logic         w_last;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_nk;

    // One expansion step from the working key and this round's Rcon.
    assign w_w0   = r_wk[127:96];
    assign w_w1   = r_wk[95:64];
    assign w_w2   = r_wk[63:32];
    assign w_w3   = r_wk[31:0];
    assign w_rot  = {w_w3[23:0], w_w3[31:24]};

    key_sub_word u_sub_word (
        .word_in  (w_rot),
        .word_out (w_sub)
    );

    assign w_temp = w_sub ^ {aes_rcon(r_rnd), 24'h000000};
    assign w_n0   = w_w0 ^ w_temp;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_nk   = {w_n0, w_n1, w_n2, w_n3};

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and step controls; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_rnd == NUM_ROUNDS) begin
                    w_last       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Key latch, round counter, status flags and round-key bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rnd        <= 4'd0;
            r_wk         <= '0;
            r_cipher_key <= '0;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int i = 1; i <= 10; i++) begin
                r_round_key[i] <= '0;
            end
        end else if (w_load) begin
            r_cipher_key <= key;
            r_wk         <= key;
            r_rnd        <= 4'd1;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
        end else if (w_step) begin
            r_wk <= w_nk;
            for (int i = 1; i <= 10; i++) begin
                if (r_rnd == 4'(i)) begin
                    r_round_key[i] <= w_nk;
                end
            end
            if (w_last) begin
                r_rnd        <= 4'd0;
                r_busy       <= 1'b0;
                r_keys_valid <= 1'b1;
            end else begin
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end

    assign busy        = r_busy;
    assign keys_valid  = r_keys_valid;
    assign cipher_key  = r_cipher_key;
    assign round1_key  = r_round_key[1];
    assign round2_key  = r_round_key[2];
    assign round3_key  = r_round_key[3];
    assign round4_key  = r_round_key[4];
    assign round5_key  = r_round_key[5];
    assign round6_key  = r_round_key[6];
    assign round7_key  = r_round_key[7];
    assign round8_key  = r_round_key[8];
    assign round9_key  = r_round_key[9];
    assign round10_key = r_round_key[10];

endmodule : aes128_key_schedule
`default_nettype wire

// File: tb/tb_aes128_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_key_schedule
//  Description : Self-checking bench for aes128_key_schedule with an
//                independent FIPS-197 key-expansion model (S-box derived
//                from GF(2^8) inversion plus the affine map).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_key_schedule;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         keys_valid;
    logic [127:0] cipher_key;
    logic [127:0] rk_out [1:10];

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] ref_rk   [1:10];
    logic [127:0] shown    [1:10];

    aes128_key_schedule dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key         (key),
        .busy        (busy),
        .keys_valid  (keys_valid),
        .cipher_key  (cipher_key),
        .round1_key  (rk_out[1]),
        .round2_key  (rk_out[2]),
        .round3_key  (rk_out[3]),
        .round4_key  (rk_out[4]),
        .round5_key  (rk_out[5]),
        .round6_key  (rk_out[6]),
        .round7_key  (rk_out[7]),
        .round8_key  (rk_out[8]),
        .round9_key  (rk_out[9]),
        .round10_key (rk_out[10])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        d = d << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] av = 8'(a);
            if (a != 0) begin
                for (int x = 1; x < 256; x++) begin
                    if (gf_mul(av, 8'(x)) == 8'h01) inv = 8'(x);
                end
            end
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook word-by-word expansion into ref_rk[1..10].
    task automatic compute_ref(input logic [127:0] k);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]],
                     sbox_ref[t[15:8]],  sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 1; r <= 10; r++)
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string when);
        for (int r = 1; r <= 10; r++)
            chk($sformatf("%s round%0d_key", when, r), rk_out[r], shown[r]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full expansion with per-edge checks; optional start/key disturbance.
    task automatic run_key(input logic [127:0] k, input bit disturb);
        compute_ref(k);
        key   = k;
        start = 1'b1;
        tick();                                  // E0
        start = 1'b0;
        chk1("E0 busy", busy, 1'b1);
        chk1("E0 keys_valid", keys_valid, 1'b0);
        chk("E0 cipher_key", cipher_key, k);
        chk_bank("E0");
        for (int n = 1; n <= 10; n++) begin
            tick();                              // En
            shown[n] = ref_rk[n];
            chk1($sformatf("E%0d busy", n), busy, (n != 10));
            chk1($sformatf("E%0d keys_valid", n), keys_valid, (n == 10));
            chk_bank($sformatf("E%0d", n));
            chk($sformatf("E%0d cipher_key", n), cipher_key, k);
            if (disturb && n == 4) begin
                start = 1'b1;
                key   = '1;
            end
            if (disturb && n == 9) start = 1'b0;
        end
        tick();                                  // idle hold
        chk1("hold busy", busy, 1'b0);
        chk1("hold keys_valid", keys_valid, 1'b1);
        chk_bank("hold");
    endtask

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] kr;
        reset = 1'b1;
        start = 1'b0;
        key   = '0;
        for (int r = 1; r <= 10; r++) shown[r] = '0;
        build_sbox();
        tick();
        tick();
        chk1("reset busy", busy, 1'b0);
        chk1("reset keys_valid", keys_valid, 1'b0);
        chk("reset cipher_key", cipher_key, '0);
        chk_bank("reset");
        reset = 1'b0;
        tick();

        // FIPS-197 A.1 with fixed vectors
        run_key(KEY_A1, 1'b0);
        chk("A1 round1", rk_out[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("A1 round2", rk_out[2], 128'hf2c295f27a96b9435935807a7359f67f);
        chk("A1 round10", rk_out[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Re-key with zero key: old keys persist until overwritten
        run_key('0, 1'b0);
        chk("zero round1", rk_out[1], 128'h62636363626363636263636362636363);
        chk("zero round10", rk_out[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // start/key changes during RUN are ignored
        run_key(KEY_A1, 1'b1);
        chk("ign round10", rk_out[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        key = '0;

        // Reset between E5 and E6
        key   = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        #2 reset = 1'b1;
        #1;
        for (int r = 1; r <= 10; r++) shown[r] = '0;
        chk1("abort busy", busy, 1'b0);
        chk1("abort keys_valid", keys_valid, 1'b0);
        chk("abort cipher_key", cipher_key, '0);
        chk_bank("abort");
        tick();
        #2 reset = 1'b0;
        tick();
        run_key(KEY_A1, 1'b0);
        chk("post-abort round10", rk_out[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Random keys against the model
        for (int t = 0; t < 3; t++) begin
            run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        // Continuous start: 11-cycle period, one-cycle keys_valid
        kr = {$urandom, $urandom, $urandom, $urandom};
        compute_ref(kr);
        key   = kr;
        start = 1'b1;
        for (int k = 0; k < 33; k++) begin
            tick();
            chk1($sformatf("cont%0d keys_valid", k), keys_valid, (k % 11 == 10));
            chk1($sformatf("cont%0d busy", k), busy, (k % 11 != 10));
            if (k % 11 == 10)
                chk($sformatf("cont%0d round10", k), rk_out[10], ref_rk[10]);
        end
        start = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_aes128_key_schedule
`default_nettype wire
